// File: rtl/prog_loader_pit.sv
// prog_loader_pit: receives a program as a LEN / DATA... / CHK byte stream,
// verifies the checksum, stores the bytes in a register-file program memory
// and serves them to the CPU. Keeps the CPU in reset until a good load ends.
module prog_loader_pit #(
  parameter int DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic [7:0] cpu_address,
  output logic [7:0] cpu_dout,
  output logic       cpu_reset,
  output logic       done,
  output logic       err,
  output logic [7:0] count
);

  // Memory index width; a one-entry memory still needs one index bit.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);
  localparam logic [7:0] HLT = 8'hF0;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_SUM  = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  // Running checksum: plain 8-bit wrap-around addition.
  function automatic logic [7:0] f_sum8(input logic [7:0] a, input logic [7:0] b);
    return 8'(a + b);
  endfunction

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [7:0]    r_len;
  logic [7:0]    r_sum;
  logic [7:0]    r_count;
  logic          r_in_ready;
  logic          r_cpu_reset;
  logic          r_done;
  logic          r_err;
  logic [7:0]    r_mem [DEPTH];
  logic          w_xfer;
  logic          w_start_acc;
  logic          w_len_bad;
  logic          w_last_data;
  logic          w_wr_en;
  logic          w_addr_ok;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;

  assign w_xfer      = in_valid & r_in_ready;
  // start only counts in the quiescent states; in LEN/DATA/SUM it is ignored.
  assign w_start_acc = start & ((r_state == S_IDLE) | (r_state == S_RUN) | (r_state == S_ERR));
  assign w_len_bad   = (in_data == 8'd0) | ({1'b0, in_data} > DEPTH_W);
  assign w_last_data = (8'(r_count + 8'd1) == r_len);
  assign w_wr_en     = (r_state == S_DATA) & w_xfer;
  assign w_wr_idx    = r_count[AW-1:0];
  assign w_rd_idx    = cpu_address[AW-1:0];
  assign w_addr_ok   = ~cpu_address[7] & ({1'b0, cpu_address} < DEPTH_W);

  assign in_ready  = r_in_ready;
  assign cpu_reset = r_cpu_reset;
  assign done      = r_done;
  assign err       = r_err;
  assign count     = r_count;

  // Next-state decode of the load sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LEN;
        else       w_next = S_IDLE;
      end
      S_LEN: begin
        if (w_xfer) w_next = w_len_bad ? S_ERR : S_DATA;
        else        w_next = S_LEN;
      end
      S_DATA: begin
        if (w_xfer && w_last_data) w_next = S_SUM;
        else                       w_next = S_DATA;
      end
      S_SUM: begin
        if (w_xfer) w_next = (in_data == r_sum) ? S_RUN : S_ERR;
        else        w_next = S_SUM;
      end
      S_RUN: begin
        if (start) w_next = S_LEN;
        else       w_next = S_RUN;
      end
      S_ERR: begin
        if (start) w_next = S_LEN;
        else       w_next = S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register plus registered decodes of the state being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == S_LEN) | (w_next == S_DATA) | (w_next == S_SUM);
      r_cpu_reset <= (w_next != S_RUN);
      r_done      <= (w_next == S_RUN);
      r_err       <= (w_next == S_ERR);
    end
  end

  // Length, checksum and byte counter for the load in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_len   <= 8'd0;
      r_sum   <= 8'd0;
      r_count <= 8'd0;
    end else if (w_start_acc) begin
      r_sum   <= 8'd0;
      r_count <= 8'd0;
    end else if ((r_state == S_LEN) && w_xfer && !w_len_bad) begin
      r_len   <= in_data;
      r_sum   <= 8'd0;
      r_count <= 8'd0;
    end else if (w_wr_en) begin
      r_sum   <= f_sum8(r_sum, in_data);
      r_count <= 8'(r_count + 8'd1);
    end else begin
      r_len   <= r_len;
      r_sum   <= r_sum;
      r_count <= r_count;
    end
  end

  // Program memory: cleared to HLT on reset, written one byte per data transfer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= HLT;
    end else if (w_wr_en) begin
      r_mem[w_wr_idx] <= in_data;
    end else begin
      r_mem <= r_mem;
    end
  end

  // CPU read port: combinational, anything outside the stored program reads as HLT.
  always_comb begin
    cpu_dout = HLT;
    if (w_addr_ok) cpu_dout = r_mem[w_rd_idx];
    else           cpu_dout = HLT;
  end

endmodule

// File: tb/tb_prog_loader_pit.sv
// Directed bench for prog_loader_pit with an expected-value scoreboard.
module tb_prog_loader_pit;

  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] cpu_address;
  logic [7:0] cpu_dout;
  logic       cpu_reset;
  logic       done;
  logic       err;
  logic [7:0] count;

  prog_loader_pit #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .cpu_address(cpu_address),
    .cpu_dout(cpu_dout), .cpu_reset(cpu_reset), .done(done), .err(err),
    .count(count)
  );

  always #5 clock = ~clock;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];
  logic [7:0] stream_q[$];
  logic [7:0] model_mem [DEPTH];
  logic [7:0] model_count;
  logic       m_done;
  logic       m_err;
  bit         gaps;

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input string tag, input logic [7:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop_cmp(input logic [7:0] obs);
    string      t;
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=%h expected=entry", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      cmp(t, obs, e);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Offer one byte and hold it until the DUT takes it (bounded).
  task automatic send_byte(input logic [7:0] b);
    logic xfer;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clock);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    xfer     = 1'b0;
    for (int i = 0; i < 16 && !xfer; i++) begin
      xfer = in_ready;
      @(negedge clock);
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    cmp("xfer_taken", {7'd0, xfer}, 8'd1);
  endtask

  // Send the stream in stream_q and update the reference model from the format.
  task automatic run_stream();
    logic [7:0] n, b, c, s;
    n = stream_q.pop_front();
    send_byte(n);
    model_count = 8'd0;
    s = 8'd0;
    if (n == 8'd0 || n > 8'(DEPTH)) begin
      m_done = 1'b0;
      m_err  = 1'b1;
      stream_q.delete();
    end else begin
      for (int k = 0; k < int'(n); k++) begin
        b = stream_q.pop_front();
        send_byte(b);
        model_mem[k] = b;
        s = 8'(s + b);
        model_count = 8'(model_count + 8'd1);
      end
      c = stream_q.pop_front();
      send_byte(c);
      m_done = (c == s);
      m_err  = (c != s);
    end
  endtask

  task automatic check_status(input logic exp_ready);
    push_exp("done", {7'd0, m_done});
    push_exp("err", {7'd0, m_err});
    push_exp("cpu_reset", {7'd0, ~m_done});
    push_exp("count", model_count);
    push_exp("in_ready", {7'd0, exp_ready});
    pop_cmp({7'd0, done});
    pop_cmp({7'd0, err});
    pop_cmp({7'd0, cpu_reset});
    pop_cmp(count);
    pop_cmp({7'd0, in_ready});
  endtask

  // Sweep the read port over the whole program area and a few out-of-range addresses.
  task automatic check_mem();
    logic [7:0] a;
    for (int i = 0; i < DEPTH + 4; i++) begin
      a = (i < DEPTH + 2) ? 8'(i) : ((i == DEPTH + 2) ? 8'h85 : 8'hFF);
      cpu_address = a;
      push_exp($sformatf("rd_%02h", a), (int'(a) < DEPTH) ? model_mem[a[3:0]] : 8'hF0);
      #1;
      pop_cmp(cpu_dout);
    end
    cpu_address = 8'd0;
    @(negedge clock);
  endtask

  task automatic hold_valid_idle(input string tag);
    logic [7:0] c0;
    c0 = count;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (3) begin
      @(negedge clock);
      cmp({tag, "_in_ready"}, {7'd0, in_ready}, 8'd0);
    end
    cmp({tag, "_count_held"}, count, c0);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    cpu_address = 8'd0; gaps = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'hF0;
    model_count = 8'd0; m_done = 1'b0; m_err = 1'b0;
    repeat (2) @(negedge clock);
    check_status(1'b0);
    reset = 1'b0;
    @(negedge clock);

    // 1: basic good load, IDLE ignores in_valid
    hold_valid_idle("idle");
    do_start();
    cmp("t1_loading_cpu_reset", {7'd0, cpu_reset}, 8'd1);
    stream_q = '{8'h03, 8'h20, 8'h80, 8'hF0, 8'h90};
    run_stream();
    check_status(1'b0);
    check_mem();

    // 2: bad checksum, then a good one-byte program
    do_start();
    stream_q = '{8'h02, 8'h11, 8'h22, 8'h00};
    run_stream();
    check_status(1'b0);
    check_mem();
    do_start();
    stream_q = '{8'h01, 8'hF0, 8'hF0};
    run_stream();
    check_status(1'b0);
    check_mem();

    // 3: zero and oversize lengths
    do_start();
    stream_q = '{8'h00};
    run_stream();
    check_status(1'b0);
    do_start();
    stream_q = '{8'h11};
    run_stream();
    check_status(1'b0);
    check_mem();
    hold_valid_idle("err");

    // 4: full-depth load with random in_valid gaps
    gaps = 1'b1;
    do_start();
    stream_q.delete();
    stream_q.push_back(8'd16);
    for (int i = 0; i < 16; i++) stream_q.push_back(8'hFF);
    stream_q.push_back(8'hF0);
    run_stream();
    gaps = 1'b0;
    check_status(1'b0);
    check_mem();
    hold_valid_idle("run");

    // 5: asynchronous reset in the middle of the data bytes
    do_start();
    send_byte(8'h04);
    send_byte(8'h01);
    send_byte(8'h02);
    cmp("t5_count_mid", count, 8'd2);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'hF0;
    model_count = 8'd0; m_done = 1'b0; m_err = 1'b0;
    check_status(1'b0);
    check_mem();
    reset = 1'b0;
    @(negedge clock);
    check_status(1'b0);

    // 6: reload while running keeps untouched bytes
    do_start();
    stream_q = '{8'h03, 8'h20, 8'h80, 8'hF0, 8'h90};
    run_stream();
    check_status(1'b0);
    do_start();
    cmp("t6_reload_cpu_reset", {7'd0, cpu_reset}, 8'd1);
    cmp("t6_reload_done", {7'd0, done}, 8'd0);
    cmp("t6_reload_count", count, 8'd0);
    stream_q = '{8'h01, 8'hAA, 8'hAA};
    run_stream();
    check_status(1'b0);
    check_mem();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
